multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the CPU datapath through FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/multicycle_sequencer_if.sv | 37 +++
 rtl/multicycle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the datapath/memories.
// master = sequencer side, slave = datapath side.
interface multicycle_sequencer_if #(
    parameter int RET_W = 32
);
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             ir_wr;
    logic             pc_wr;
    logic             pc_src;
    logic             brnch;
    logic             mem_rd;
    logic             mem_wr;
    logic             mem_to_rgs;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic             reg_wr;
    logic [2:0]       state;
    logic             trap;
    logic [RET_W-1:0] retired;

    modport master (
        input  opcode, branch_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, ir_wr, pc_wr, pc_src, brnch, mem_rd, mem_wr,
               mem_to_rgs, alu_src, alu_op, reg_wr, state, trap, retired
    );

    modport slave (
        output opcode, branch_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ir_wr, pc_wr, pc_src, brnch, mem_rd, mem_wr,
               mem_to_rgs, alu_src, alu_op, reg_wr, state, trap, retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with a memory-ack
// watchdog, sticky trap and retired-instruction counter.
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int RET_W   = 32
) (
    input logic                   clock,
    input logic                   reset,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_ST  = 3'd3,
        CL_BR  = 3'd4,
        CL_ILL = 3'd5
    } class_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_RFUNC = 4'd2;
    localparam logic [3:0] ALU_IFUNC = 4'd3;

    // The watchdog only needs to count up to TIMEOUT-1 before the trap fires.
    localparam int              WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           r_state;
    class_t           r_class;
    logic [WDW-1:0]   r_wdog;
    logic [RET_W-1:0] r_retired;
    logic             r_trap;

    state_t     w_nextState;
    class_t     w_decClass;
    logic       w_retire;
    logic       w_waiting;
    logic       w_expired;
    logic       w_imemReq;
    logic       w_dmemReq;
    logic       w_irWr;
    logic       w_pcWr;
    logic       w_pcSrc;
    logic       w_brnch;
    logic       w_memRd;
    logic       w_memWr;
    logic       w_memToRgs;
    logic       w_aluSrc;
    logic [3:0] w_aluOp;
    logic       w_regWr;

    always_comb begin
        case (bus.opcode)
            7'b0110011: w_decClass = CL_R;
            7'b0010011: w_decClass = CL_I;
            7'b0000011: w_decClass = CL_LD;
            7'b0100011: w_decClass = CL_ST;
            7'b1100011: w_decClass = CL_BR;
            default:    w_decClass = CL_ILL;
        endcase
    end

    assign w_waiting = ((r_state == ST_FETCH) && !bus.imem_ack) ||
                       ((r_state == ST_MEM)   && !bus.dmem_ack);
    assign w_expired = (TIMEOUT != 0) && (r_wdog == WD_LAST);

    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        w_imemReq   = 1'b0;
        w_dmemReq   = 1'b0;
        w_irWr      = 1'b0;
        w_pcWr      = 1'b0;
        w_pcSrc     = 1'b0;
        w_brnch     = 1'b0;
        w_memRd     = 1'b0;
        w_memWr     = 1'b0;
        w_memToRgs  = 1'b0;
        w_aluSrc    = 1'b0;
        w_aluOp     = ALU_ADD;
        w_regWr     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_imemReq = 1'b1;
                if (bus.imem_ack) begin
                    w_irWr      = 1'b1;
                    w_pcWr      = 1'b1;
                    w_nextState = ST_DECODE;
                end else if (w_expired) begin
                    w_nextState = ST_TRAP;
                end
            end
            ST_DECODE: begin
                w_nextState = (w_decClass == CL_ILL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (r_class)
                    CL_R: begin
                        w_aluOp     = ALU_RFUNC;
                        w_nextState = ST_WB;
                    end
                    CL_I: begin
                        w_aluOp     = ALU_IFUNC;
                        w_aluSrc    = 1'b1;
                        w_nextState = ST_WB;
                    end
                    CL_LD, CL_ST: begin
                        w_aluOp     = ALU_ADD;
                        w_aluSrc    = 1'b1;
                        w_nextState = ST_MEM;
                    end
                    CL_BR: begin
                        w_brnch     = 1'b1;
                        w_aluOp     = ALU_SUB;
                        w_pcWr      = bus.branch_taken;
                        w_pcSrc     = 1'b1;
                        w_retire    = 1'b1;
                        w_nextState = ST_FETCH;
                    end
                    default: w_nextState = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                w_dmemReq = 1'b1;
                w_memRd   = (r_class == CL_LD);
                w_memWr   = (r_class == CL_ST);
                if (bus.dmem_ack) begin
                    w_nextState = (r_class == CL_LD) ? ST_WB : ST_FETCH;
                    w_retire    = (r_class != CL_LD);
                end else if (w_expired) begin
                    w_nextState = ST_TRAP;
                end
            end
            ST_WB: begin
                w_regWr     = 1'b1;
                w_memToRgs  = (r_class == CL_LD);
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
            end
            ST_TRAP: w_nextState = ST_TRAP;
            default: w_nextState = ST_FETCH;
        endcase

        // Reset abandons the current instruction: nothing may be written this cycle.
        if (reset) begin
            w_nextState = ST_FETCH;
            w_retire    = 1'b0;
            w_imemReq   = 1'b0;
            w_dmemReq   = 1'b0;
            w_irWr      = 1'b0;
            w_pcWr      = 1'b0;
            w_pcSrc     = 1'b0;
            w_brnch     = 1'b0;
            w_memRd     = 1'b0;
            w_memWr     = 1'b0;
            w_memToRgs  = 1'b0;
            w_aluSrc    = 1'b0;
            w_aluOp     = ALU_ADD;
            w_regWr     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_class   <= CL_R;
            r_wdog    <= '0;
            r_retired <= '0;
            r_trap    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_DECODE) begin
                r_class <= w_decClass;
            end
            r_wdog <= w_waiting ? r_wdog + 1'b1 : '0;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_nextState == ST_TRAP) begin
                r_trap <= 1'b1;
            end
        end
    end

    assign bus.imem_req   = w_imemReq;
    assign bus.dmem_req   = w_dmemReq;
    assign bus.ir_wr      = w_irWr;
    assign bus.pc_wr      = w_pcWr;
    assign bus.pc_src     = w_pcSrc;
    assign bus.brnch      = w_brnch;
    assign bus.mem_rd     = w_memRd;
    assign bus.mem_wr     = w_memWr;
    assign bus.mem_to_rgs = w_memToRgs;
    assign bus.alu_src    = w_aluSrc;
    assign bus.alu_op     = w_aluOp;
    assign bus.reg_wr     = w_regWr;
    assign bus.state      = reset ? 3'd0 : r_state;
    assign bus.trap       = r_trap & ~reset;
    assign bus.retired    = reset ? '0 : r_retired;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: each instruction is expanded into an
// expected per-cycle trace from the phase rules, then replayed and compared.
module tb_multicycle_sequencer;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    multicycle_sequencer_if #(.RET_W(4)) bus();

    multicycle_sequencer #(.TIMEOUT(15), .RET_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       dreq;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       br;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       asrc;
        logic [3:0] aop;
        logic       rw;
        logic       tr;
    } out_t;

    typedef struct packed {
        logic [6:0] opc;
        logic       ia;
        logic       da;
        logic       bt;
        out_t       exp;
    } cyc_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    cyc_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   retCount = 0;
    out_t obs;

    assign obs = {bus.state, bus.imem_req, bus.dmem_req, bus.ir_wr, bus.pc_wr, bus.pc_src,
                  bus.brnch, bus.mem_rd, bus.mem_wr, bus.mem_to_rgs, bus.alu_src,
                  bus.alu_op, bus.reg_wr, bus.trap};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // 0=R 1=I 2=LD 3=ST 4=BR 5=illegal
    function automatic int classOf(input logic [6:0] opc);
        case (opc)
            OP_R:    return 0;
            OP_I:    return 1;
            OP_LD:   return 2;
            OP_ST:   return 3;
            OP_BR:   return 4;
            default: return 5;
        endcase
    endfunction

    task automatic pushCyc(input logic [6:0] opc, input logic ia, input logic da,
                           input logic bt, input out_t o);
        cyc_t c;
        c.opc = opc;
        c.ia  = ia;
        c.da  = da;
        c.bt  = bt;
        c.exp = o;
        q.push_back(c);
    endtask

    task automatic addTrap(input int n);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o    = '0;
            o.st = 3'd5;
            o.tr = 1'b1;
            pushCyc(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), o);
        end
    endtask

    // A wait of 15 or more means the ack never comes and the watchdog fires.
    task automatic buildInstr(input logic [6:0] opc, input int iWait, input int dWait,
                              input logic taken, input int trapCycles, output bit retires);
        out_t o;
        int   cls = classOf(opc);
        int   nf  = (iWait > 15) ? 15 : iWait;
        int   nd  = (dWait > 15) ? 15 : dWait;
        retires = 1'b0;
        for (int i = 0; i < nf; i++) begin
            o = '0; o.st = 3'd0; o.ireq = 1'b1;
            pushCyc(7'($urandom), 1'b0, 1'($urandom), 1'($urandom), o);
        end
        if (iWait >= 15) begin
            addTrap(trapCycles);
            return;
        end
        o = '0; o.st = 3'd0; o.ireq = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        pushCyc(7'($urandom), 1'b1, 1'($urandom), 1'($urandom), o);
        o = '0; o.st = 3'd1;
        pushCyc(opc, 1'($urandom), 1'($urandom), 1'($urandom), o);
        if (cls == 5) begin
            addTrap(trapCycles);
            return;
        end
        o = '0; o.st = 3'd2;
        case (cls)
            0: o.aop = 4'd2;
            1: begin o.aop = 4'd3; o.asrc = 1'b1; end
            2, 3: begin o.aop = 4'd0; o.asrc = 1'b1; end
            default: begin o.br = 1'b1; o.aop = 4'd1; o.pcw = taken; o.pcs = 1'b1; end
        endcase
        pushCyc(7'($urandom), 1'($urandom), 1'($urandom),
                (cls == 4) ? taken : 1'($urandom), o);
        if (cls == 2 || cls == 3) begin
            o = '0; o.st = 3'd3; o.dreq = 1'b1;
            o.mrd = (cls == 2); o.mwr = (cls == 3);
            for (int i = 0; i < nd; i++) begin
                pushCyc(7'($urandom), 1'($urandom), 1'b0, 1'($urandom), o);
            end
            if (dWait >= 15) begin
                addTrap(trapCycles);
                return;
            end
            pushCyc(7'($urandom), 1'($urandom), 1'b1, 1'($urandom), o);
        end
        if (cls != 3 && cls != 4) begin
            o = '0; o.st = 3'd4; o.rw = 1'b1; o.m2r = (cls == 2);
            pushCyc(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), o);
        end
        retires = 1'b1;
    endtask

    // Replays the queued trace: drive just after the rising edge, compare on the falling edge.
    task automatic applyStimulus(input string name);
        for (int i = 0; i < q.size(); i++) begin
            bus.opcode       = q[i].opc;
            bus.imem_ack     = q[i].ia;
            bus.dmem_ack     = q[i].da;
            bus.branch_taken = q[i].bt;
            @(negedge clock);
            checkOutput($sformatf("%s.c%0d", name, i), 32'(obs), 32'(q[i].exp));
            @(posedge clock);
            #1;
        end
        q.delete();
    endtask

    task automatic runInstr(input string name, input logic [6:0] opc, input int iWait,
                            input int dWait, input logic taken, input int trapCycles);
        bit retires;
        buildInstr(opc, iWait, dWait, taken, trapCycles, retires);
        applyStimulus(name);
        if (retires) retCount++;
        checkOutput({name, ".ret"}, 32'(bus.retired), 32'(retCount % 16));
    endtask

    task automatic doReset(input int n, input logic da);
        reset            = 1'b1;
        bus.dmem_ack     = da;
        bus.imem_ack     = 1'($urandom);
        bus.branch_taken = 1'($urandom);
        bus.opcode       = 7'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput("rst.out", 32'(obs), 32'd0);
            checkOutput("rst.ret", 32'(bus.retired), 32'd0);
            @(posedge clock);
            #1;
        end
        reset    = 1'b0;
        retCount = 0;
    endtask

    initial begin
        logic [6:0] legal [5];
        logic [6:0] opc;
        bit         dummy;
        legal[0] = OP_R; legal[1] = OP_I; legal[2] = OP_LD; legal[3] = OP_ST; legal[4] = OP_BR;

        reset            = 1'b1;
        bus.opcode       = '0;
        bus.imem_ack     = 1'b0;
        bus.dmem_ack     = 1'b0;
        bus.branch_taken = 1'b0;
        @(posedge clock);
        #1;
        doReset(2, 1'b0);

        runInstr("t1_r", OP_R, 0, 0, 1'b0, 0);
        runInstr("t2_ld", OP_LD, 0, 3, 1'b0, 0);
        runInstr("t3_br_t", OP_BR, 0, 0, 1'b1, 0);
        runInstr("t3_br_n", OP_BR, 0, 0, 1'b0, 0);
        runInstr("st0", OP_ST, 0, 0, 1'b0, 0);
        runInstr("i_wait", OP_I, 2, 0, 1'b0, 0);
        runInstr("fetch_ack15", OP_I, 14, 0, 1'b0, 0);
        runInstr("mem_ack15", OP_ST, 0, 14, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            opc = legal[$urandom_range(0, 4)];
            runInstr($sformatf("rnd%0d", n), opc,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                     1'($urandom), 0);
        end

        runInstr("t4_ill", 7'b1111111, 0, 0, 1'b0, 20);
        doReset(1, 1'b0);
        runInstr("t4_after", OP_R, 0, 0, 1'b0, 0);

        do opc = 7'($urandom); while (classOf(opc) != 5);
        runInstr("ill_rnd", opc, 1, 0, 1'b0, 4);
        doReset(1, 1'b0);

        runInstr("t5_fetch_to", OP_R, 15, 0, 1'b0, 5);
        doReset(1, 1'b0);
        runInstr("mem_to", OP_LD, 0, 15, 1'b0, 5);
        doReset(1, 1'b0);

        runInstr("pre_t6", OP_R, 0, 0, 1'b0, 0);
        buildInstr(OP_ST, 0, 2, 1'b0, 0, dummy);
        void'(q.pop_back());
        applyStimulus("t6_st");
        doReset(1, 1'b1);
        runInstr("t6_post", OP_R, 0, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
